// File: rtl/delay_line_buf.sv
// rtl/delay_line_buf.sv - RAM-backed variable pixel delay line with zero-fill priming, flush and beat counter
// Returns the sample accepted min(delay, MAX_DELAY) beats earlier, or zero while history is too short.
module delay_line_buf #(
    parameter int DATA_WIDTH = 24,
    parameter int MAX_DELAY  = 640,
    parameter int DELAY_W    = $clog2(MAX_DELAY + 1),
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [DELAY_W-1:0]    delay,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [DELAY_W-1:0]    fill_cnt,
    output logic [CNT_W-1:0]      beat_cnt
);

    localparam int PTR_W = (MAX_DELAY > 2) ? $clog2(MAX_DELAY) : 1;
    localparam logic [DELAY_W-1:0] MAX_D    = DELAY_W'(MAX_DELAY);
    localparam logic [DELAY_W-1:0] LAST_PTR = DELAY_W'(MAX_DELAY - 1);

    localparam logic [1:0] SEL_ZERO = 2'd0;
    localparam logic [1:0] SEL_PASS = 2'd1;
    localparam logic [1:0] SEL_RAM  = 2'd2;

    logic [DATA_WIDTH-1:0] mem [MAX_DELAY];
    logic [DATA_WIDTH-1:0] ram_rd_q;

    logic [DELAY_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [DELAY_W-1:0]    fill_q, fill_d;
    logic [CNT_W-1:0]      beat_q, beat_d;
    logic                  vld_q, vld_d;
    logic [1:0]            sel_q, sel_d;
    logic [DATA_WIDTH-1:0] pass_q, pass_d;

    logic [DELAY_W-1:0]    d_eff;
    logic [DELAY_W-1:0]    ptr_base;
    logic [DELAY_W-1:0]    fill_base;
    logic [CNT_W-1:0]      beat_base;
    logic [DELAY_W-1:0]    rd_full;
    logic [PTR_W-1:0]      rd_addr;
    logic [PTR_W-1:0]      wr_addr;

    // A flush beat starts a fresh history, so it sees pointer/fill/count as zero.
    always_comb begin
        d_eff     = (delay > MAX_D) ? MAX_D : delay;
        ptr_base  = flush ? '0 : wr_ptr_q;
        fill_base = flush ? '0 : fill_q;
        beat_base = flush ? '0 : beat_q;
        if (d_eff > ptr_base) begin
            rd_full = ptr_base + (MAX_D - d_eff);
        end else begin
            rd_full = ptr_base - d_eff;
        end
        rd_addr = PTR_W'(rd_full);
        wr_addr = PTR_W'(ptr_base);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        beat_d   = beat_q;
        sel_d    = sel_q;
        pass_d   = pass_q;
        vld_d    = i_valid;
        if (flush) begin
            wr_ptr_d = '0;
            fill_d   = '0;
            beat_d   = '0;
        end
        if (i_valid) begin
            wr_ptr_d = (ptr_base == LAST_PTR) ? '0 : ptr_base + 1'b1;
            fill_d   = (fill_base == MAX_D) ? MAX_D : fill_base + 1'b1;
            beat_d   = beat_base + 1'b1;
            pass_d   = i_data;
            // Stale RAM words are masked whenever the requested delay reaches past held history.
            if (d_eff == '0) begin
                sel_d = SEL_PASS;
            end else if (d_eff > fill_base) begin
                sel_d = SEL_ZERO;
            end else begin
                sel_d = SEL_RAM;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            fill_q   <= '0;
            beat_q   <= '0;
            vld_q    <= 1'b0;
            sel_q    <= SEL_ZERO;
            pass_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            beat_q   <= beat_d;
            vld_q    <= vld_d;
            sel_q    <= sel_d;
            pass_q   <= pass_d;
        end
    end

    // Read-before-write: a full-depth delay reads the word about to be overwritten.
    always_ff @(posedge clk) begin
        if (i_valid) begin
            ram_rd_q      <= mem[rd_addr];
            mem[wr_addr]  <= i_data;
        end
    end

    always_comb begin
        case (sel_q)
            SEL_PASS: o_data = pass_q;
            SEL_RAM:  o_data = ram_rd_q;
            default:  o_data = '0;
        endcase
    end

    assign o_valid  = vld_q;
    assign fill_cnt = fill_q;
    assign beat_cnt = beat_q;

endmodule

// File: tb/tb_delay_line_buf.sv
// tb/tb_delay_line_buf.sv - randomized scoreboard bench for delay_line_buf against a history-list model
module tb_delay_line_buf;

    localparam int DW  = 24;
    localparam int MD  = 640;
    localparam int DLW = $clog2(MD + 1);
    localparam int CW  = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           flush = 1'b0;
    logic           i_valid = 1'b0;
    logic [DW-1:0]  i_data = '0;
    logic [DLW-1:0] delay = '0;
    logic           o_valid;
    logic [DW-1:0]  o_data;
    logic [DLW-1:0] fill_cnt;
    logic [CW-1:0]  beat_cnt;

    delay_line_buf #(.DATA_WIDTH(DW), .MAX_DELAY(MD), .DELAY_W(DLW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .i_valid(i_valid), .i_data(i_data),
        .delay(delay), .o_valid(o_valid), .o_data(o_data),
        .fill_cnt(fill_cnt), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] hist[$];
    logic [DW-1:0] exp_q[$];
    int            fill_m = 0;
    int            beat_m = 0;
    logic          exp_vld = 1'b0;
    logic [DW-1:0] last_exp = '0;

    task automatic chk(string name, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected output follows directly from the beat index and the list of samples since flush.
    task automatic step(bit v, bit fl, int dl, logic [DW-1:0] x);
        int k;
        int d;
        i_valid = v;
        flush   = fl;
        delay   = DLW'(dl);
        i_data  = x;
        @(posedge clk);
        if (fl) begin
            hist.delete();
            fill_m = 0;
            beat_m = 0;
        end
        if (v) begin
            k = hist.size();
            d = (dl > MD) ? MD : dl;
            if (d == 0)      exp_q.push_back(x);
            else if (k >= d) exp_q.push_back(hist[k - d]);
            else             exp_q.push_back('0);
            hist.push_back(x);
            fill_m = (fill_m < MD) ? fill_m + 1 : MD;
            beat_m = (beat_m + 1) % (1 << CW);
        end
        exp_vld = v;
        #1;
    endtask

    always @(negedge clk) begin
        logic [DW-1:0] e;
        chk("o_valid", longint'(o_valid), longint'(exp_vld));
        if (o_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL o_valid_extra: got output %0d expected no beat at %0t", o_data, $time);
            end else begin
                e = exp_q.pop_front();
                chk("o_data", longint'(o_data), longint'(e));
                last_exp = e;
            end
        end else begin
            chk("o_data_hold", longint'(o_data), longint'(last_exp));
        end
        chk("fill_cnt", longint'(fill_cnt), longint'(fill_m));
        chk("beat_cnt", longint'(beat_cnt), longint'(beat_m));
    end

    task automatic do_reset_mid();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_o_valid", longint'(o_valid), 0);
        chk("rst_o_data", longint'(o_data), 0);
        chk("rst_fill", longint'(fill_cnt), 0);
        chk("rst_beat", longint'(beat_cnt), 0);
        hist.delete();
        exp_q.delete();
        fill_m = 0;
        beat_m = 0;
        exp_vld = 1'b0;
        last_exp = '0;
        i_valid = 1'b0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        chk("init_o_valid", longint'(o_valid), 0);
        chk("init_o_data", longint'(o_data), 0);
        chk("init_fill", longint'(fill_cnt), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < 10; k++) step(1, 0, 3, DW'(k + 1));
        step(0, 0, 3, '0);

        step(0, 1, 0, '0);
        for (int k = 0; k < 1300; k++) step(1, 0, 0, DW'($urandom));
        step(0, 1, 0, '0);
        for (int k = 0; k < 1300; k++) step(1, 0, 1000, DW'($urandom));

        step(0, 1, 2, '0);
        for (int c = 0; c < 40; c++) step(c % 2 == 0, 0, 2, DW'($urandom));

        step(0, 1, 5, '0);
        for (int k = 0; k < 10; k++) step(1, 0, 5, DW'($urandom));
        for (int k = 0; k < 20; k++) step(1, 0, 20, DW'($urandom));
        for (int k = 0; k < 10; k++) step(1, 0, 2, DW'($urandom));

        step(0, 1, 4, '0);
        for (int k = 0; k < 700; k++) step(1, 0, 4, DW'($urandom));
        step(1, 1, 4, DW'($urandom));
        for (int k = 0; k < 10; k++) step(1, 0, 4, DW'($urandom));

        for (int c = 0; c < 3000; c++) begin
            int dl;
            dl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 8));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0, dl, DW'($urandom));
        end

        step(1, 0, 1, DW'($urandom));
        do_reset_mid();
        for (int k = 0; k < 20; k++) step(1, 0, 1, DW'($urandom));
        repeat (3) step(0, 0, 1, '0);

        chk("scoreboard_drained", longint'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
